// File: rtl/maj_net_seq_eval_if.sv
// maj_net_seq_eval_if: config, request and result signals of the majority-network evaluator
interface maj_net_seq_eval_if #(
  parameter int NUM_IN = 7,
  parameter int MAX_GATES = 8,
  parameter int SEL_W = $clog2(NUM_IN + MAX_GATES + 1)
);
  logic cfg_we;
  logic [$clog2(MAX_GATES)-1:0] cfg_addr;
  logic [SEL_W-1:0] cfg_a, cfg_b, cfg_c;
  logic [3:0] cfg_inv;
  logic [$clog2(MAX_GATES+1)-1:0] cfg_num_gates;
  logic [SEL_W-1:0] cfg_out_sel;
  logic in_valid, in_ready, in_sweep;
  logic [NUM_IN-1:0] in_x;
  logic out_valid, out_ready, out_bit;
  logic [2**NUM_IN-1:0] out_tt;
  modport master (
    output cfg_we, cfg_addr, cfg_a, cfg_b, cfg_c, cfg_inv, cfg_num_gates, cfg_out_sel,
    output in_valid, in_x, in_sweep, out_ready,
    input in_ready, out_valid, out_bit, out_tt
  );
  modport slave (
    input cfg_we, cfg_addr, cfg_a, cfg_b, cfg_c, cfg_inv, cfg_num_gates, cfg_out_sel,
    input in_valid, in_x, in_sweep, out_ready,
    output in_ready, out_valid, out_bit, out_tt
  );
endinterface

// File: rtl/maj_net_seq_eval.sv
// maj_net_seq_eval: one-gate-per-cycle MAJ-3 network evaluator (single bit or full truth table); MAJ_INV_EN adds complemented edges
module maj_net_seq_eval #(
  parameter int NUM_IN = 7,
  parameter int MAX_GATES = 8,
  parameter int SEL_W = $clog2(NUM_IN + MAX_GATES + 1)
) (
  input logic clk,
  input logic rst_n,
  maj_net_seq_eval_if.slave s
);
  localparam int AW = $clog2(MAX_GATES);
  localparam int CW = $clog2(MAX_GATES + 1);
  localparam int TT = 2 ** NUM_IN;
  localparam logic [CW-1:0] MAXG = CW'(MAX_GATES);
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
`ifdef MAJ_INV_EN
  typedef struct packed {logic [3:0] inv; logic [SEL_W-1:0] a, b, c;} gate_t;
`else
  typedef struct packed {logic [SEL_W-1:0] a, b, c;} gate_t;
  logic unused_inv;
  assign unused_inv = ^s.cfg_inv;
`endif
  state_t state_q, state_d;
  gate_t gate_q [MAX_GATES];
  gate_t gate_d [MAX_GATES];
  gate_t cur;
  logic [CW-1:0] num_q, num_d, geff;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [AW-1:0] g_q, g_d;
  logic [NUM_IN-1:0] x_q, x_d;
  logic [MAX_GATES-1:0] node_q, node_d, node_n;
  logic [TT-1:0] tt_q, tt_d;
  logic sweep_q, sweep_d, vld_q, vld_d, bit_q, bit_d;
  logic [3:0] inv;
  logic va, vb, vc, nv, res, last_g;

  // Gate operands may only see gates below lim; anything else (forward refs, unused codes) reads 0
  function automatic logic pick(input logic [SEL_W-1:0] c, input logic [NUM_IN-1:0] xv,
                                input logic [MAX_GATES-1:0] nv_in, input int lim);
    int i;
    i = int'(c);
    if (i >= 1 && i <= NUM_IN) return 1'(xv >> (i - 1));
    if (i > NUM_IN && i - NUM_IN - 1 < lim) return 1'(nv_in >> (i - NUM_IN - 1));
    return 1'b0;
  endfunction

  // Evaluate the current gate and the result node as seen once this gate is written
  always_comb begin
    geff = (num_q > MAXG) ? MAXG : num_q;
    cur = gate_q[g_q];
`ifdef MAJ_INV_EN
    inv = cur.inv;
`else
    inv = 4'b0;
`endif
    va = pick(cur.a, x_q, node_q, int'(g_q)) ^ inv[0];
    vb = pick(cur.b, x_q, node_q, int'(g_q)) ^ inv[1];
    vc = pick(cur.c, x_q, node_q, int'(g_q)) ^ inv[2];
    nv = ((va & vb) | (va & vc) | (vb & vc)) ^ inv[3];
    node_n = node_q;
    node_n[g_q] = nv;
    res = pick(sel_q, x_q, node_n, int'(geff));
    last_g = int'(g_q) + 1 >= int'(geff);
  end

  // Control FSM: config writes and request accept in IDLE, gate stepping in EVAL, result hold in DONE
  always_comb begin
    state_d = state_q;
    gate_d = gate_q;
    num_d = num_q;
    sel_d = sel_q;
    g_d = g_q;
    x_d = x_q;
    sweep_d = sweep_q;
    node_d = node_q;
    tt_d = tt_q;
    bit_d = bit_q;
    vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s.cfg_we) begin
          gate_d[s.cfg_addr].a = s.cfg_a;
          gate_d[s.cfg_addr].b = s.cfg_b;
          gate_d[s.cfg_addr].c = s.cfg_c;
`ifdef MAJ_INV_EN
          gate_d[s.cfg_addr].inv = s.cfg_inv;
`endif
          num_d = s.cfg_num_gates;
          sel_d = s.cfg_out_sel;
        end
        if (s.in_valid) begin
          state_d = EVAL;
          g_d = '0;
          sweep_d = s.in_sweep;
          x_d = s.in_sweep ? '0 : s.in_x;
          tt_d = s.in_sweep ? '0 : tt_q;
        end
      end
      EVAL: begin
        node_d = node_n;
        g_d = last_g ? '0 : g_q + 1'b1;
        if (last_g) begin
          if (sweep_q) tt_d[x_q] = res;
          else bit_d = res;
          x_d = x_q + 1'b1;
          if (!sweep_q || &x_q) state_d = DONE;
        end
      end
      DONE: begin
        vld_d = !(vld_q && s.out_ready);
        if (vld_q && s.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset also wipes the loaded network
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gate_q <= '{default: '0};
      num_q <= '0;
      sel_q <= '0;
      g_q <= '0;
      x_q <= '0;
      sweep_q <= 1'b0;
      node_q <= '0;
      tt_q <= '0;
      bit_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q <= gate_d;
      num_q <= num_d;
      sel_q <= sel_d;
      g_q <= g_d;
      x_q <= x_d;
      sweep_q <= sweep_d;
      node_q <= node_d;
      tt_q <= tt_d;
      bit_q <= bit_d;
      vld_q <= vld_d;
    end
  end

  assign s.in_ready = state_q == IDLE;
  assign s.out_valid = vld_q;
  assign s.out_bit = bit_q;
  assign s.out_tt = tt_q;
endmodule
